// File: rtl/pe_pkg.sv
// Shared definitions for the PE feeder slice.
//  - state_t   : feeder FSM encoding (IDLE/RUN/DRAIN/DONE)
//  - CTL_FIRST : pe_ctl bit that tells the PE to clear its partial sum
//  - CTL_LAST  : pe_ctl bit that tells the PE the dot product is complete
//  - PE_DATA_W : width of a PE result word
//  - CHUNK_W   : width of one neuron/weight chunk streamed from SRAM
//  - relu()    : clamp negative two's-complement results to zero
package pe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int CTL_W     = 2;
  localparam int CTL_FIRST = 0;
  localparam int CTL_LAST  = 1;
  localparam int PE_DATA_W = 32;
  localparam int CHUNK_W   = 512;

  function automatic logic [PE_DATA_W-1:0] relu(input logic [PE_DATA_W-1:0] value);
    return value[PE_DATA_W-1] ? '0 : value;
  endfunction

endpackage

// File: rtl/pe_addr_gen.sv
// Address/counter generator for pe_feeder.
//  Holds the chunk index (neuron address), the running weight address, the count of
//  outputs whose reads have all been issued, and the writeback output counter.
// Ports:
//  clk, rst_n      clock, async active-low reset
//  clear           zero every counter (asserted on start acceptance)
//  issue           a read is issued this cycle
//  wr              a result is written this cycle
//  in_chunks       latched chunks per output
//  out_num         latched number of outputs
//  chunk_idx       current chunk index i
//  weight_idx      current running weight address
//  wr_idx          current output buffer address
//  first / last    chunk_idx is the first / last chunk of an output
//  last_issue      current read is the very last one of the job
module pe_addr_gen
  import pe_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int OUT_W   = 8,
  parameter int WADDR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               issue,
  input  logic               wr,
  input  logic [CNT_W-1:0]   in_chunks,
  input  logic [OUT_W-1:0]   out_num,
  output logic [CNT_W-1:0]   chunk_idx,
  output logic [WADDR_W-1:0] weight_idx,
  output logic [OUT_W-1:0]   wr_idx,
  output logic               first,
  output logic               last,
  output logic               last_issue
);

  logic [CNT_W-1:0]   chunk_reg;
  logic [WADDR_W-1:0] weight_reg;
  logic [OUT_W-1:0]   issued_out_reg;
  logic [OUT_W-1:0]   wr_reg;

  // With in_chunks==1 both flags are set on every issue, as required by the PE.
  assign first      = (chunk_reg == '0);
  assign last       = (chunk_reg == in_chunks - CNT_W'(1));
  assign last_issue = last && (issued_out_reg == out_num - OUT_W'(1));

  assign chunk_idx  = chunk_reg;
  assign weight_idx = weight_reg;
  assign wr_idx     = wr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chunk_reg      <= '0;
      weight_reg     <= '0;
      issued_out_reg <= '0;
      wr_reg         <= '0;
    end else if (clear) begin
      chunk_reg      <= '0;
      weight_reg     <= '0;
      issued_out_reg <= '0;
      wr_reg         <= '0;
    end else begin
      if (issue) begin
        // Neuron address wraps per output; weight address keeps running.
        chunk_reg  <= last ? '0 : chunk_reg + CNT_W'(1);
        weight_reg <= weight_reg + WADDR_W'(1);
        if (last) begin
          issued_out_reg <= issued_out_reg + OUT_W'(1);
        end
      end
      if (wr) begin
        wr_reg <= wr_reg + OUT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pe_feeder.sv
// pe_feeder: sequencer in front of the parallel PE.
//  Streams in_chunks*out_num neuron/weight chunk reads (one per cycle), drives the PE's
//  vld/ctl one cycle later (aligned with SRAM read data), and writes each PE result to
//  the output buffer. done pulses one cycle after the final write.
// Configuration macro: PE_FEEDER_RELU_EN -- when defined, negative results are written as 0.
// Ports:
//  clk, rst_n                   clock, async active-low reset
//  start, in_chunks, out_num    job request (sampled/latched in IDLE only)
//  neuron_rd_en, neuron_addr    neuron SRAM read port
//  weight_rd_en, weight_addr    weight SRAM read port
//  pe_vld, pe_ctl               to PE vld_i / ctl (ctl[0]=first, ctl[1]=last)
//  pe_vld_o, pe_result          from PE
//  out_wr_en, out_addr, out_data  output buffer write port
//  busy, done                   status
module pe_feeder
  import pe_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int OUT_W   = 8,
  parameter int WADDR_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_W-1:0]     in_chunks,
  input  logic [OUT_W-1:0]     out_num,
  output logic                 neuron_rd_en,
  output logic [CNT_W-1:0]     neuron_addr,
  output logic                 weight_rd_en,
  output logic [WADDR_W-1:0]   weight_addr,
  output logic                 pe_vld,
  output logic [CTL_W-1:0]     pe_ctl,
  input  logic                 pe_vld_o,
  input  logic [PE_DATA_W-1:0] pe_result,
  output logic                 out_wr_en,
  output logic [OUT_W-1:0]     out_addr,
  output logic [PE_DATA_W-1:0] out_data,
  output logic                 busy,
  output logic                 done
);

  state_t state_reg, state_next;

  logic [CNT_W-1:0]     in_chunks_reg;
  logic [OUT_W-1:0]     out_num_reg;
  logic                 accept;
  logic                 zero_job;
  logic                 issue;
  logic                 wr;
  logic                 writes_done;
  logic [CNT_W-1:0]     chunk_idx;
  logic [WADDR_W-1:0]   weight_idx;
  logic [OUT_W-1:0]     wr_idx;
  logic                 first;
  logic                 last;
  logic                 last_issue;
  logic [CTL_W-1:0]     ctl_issue;
  logic                 pe_vld_reg;
  logic [CTL_W-1:0]     pe_ctl_reg;
  logic [PE_DATA_W-1:0] wb_data;

  assign accept   = (state_reg == ST_IDLE) && start;
  assign zero_job = (in_chunks == '0) || (out_num == '0);
  assign issue    = (state_reg == ST_RUN);
  // Results arriving while idle (e.g. in flight across a reset) are dropped.
  assign wr       = pe_vld_o && ((state_reg == ST_RUN) || (state_reg == ST_DRAIN));

  // All results written: either already counted, or the last one lands this cycle.
  assign writes_done = (wr_idx == out_num_reg) ||
                       (wr && (wr_idx == out_num_reg - OUT_W'(1)));

  pe_addr_gen #(
    .CNT_W   (CNT_W),
    .OUT_W   (OUT_W),
    .WADDR_W (WADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (accept),
    .issue      (issue),
    .wr         (wr),
    .in_chunks  (in_chunks_reg),
    .out_num    (out_num_reg),
    .chunk_idx  (chunk_idx),
    .weight_idx (weight_idx),
    .wr_idx     (wr_idx),
    .first      (first),
    .last       (last),
    .last_issue (last_issue)
  );

  // Job parameters are captured only when a start is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_chunks_reg <= '0;
      out_num_reg   <= '0;
    end else if (accept) begin
      in_chunks_reg <= in_chunks;
      out_num_reg   <= out_num;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = zero_job ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_issue) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (writes_done) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    ctl_issue            = '0;
    ctl_issue[CTL_FIRST] = first;
    ctl_issue[CTL_LAST]  = last;
  end

  // One register stage matches the SRAM read latency so vld/ctl line up with data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_vld_reg <= 1'b0;
      pe_ctl_reg <= '0;
    end else begin
      pe_vld_reg <= issue;
      pe_ctl_reg <= issue ? ctl_issue : '0;
    end
  end

`ifdef PE_FEEDER_RELU_EN
  assign wb_data = relu(pe_result);
`else
  assign wb_data = pe_result;
`endif

  assign neuron_rd_en = issue;
  assign weight_rd_en = issue;
  assign neuron_addr  = issue ? chunk_idx : '0;
  assign weight_addr  = issue ? weight_idx : '0;
  assign pe_vld       = pe_vld_reg;
  assign pe_ctl       = pe_ctl_reg;
  assign out_wr_en    = wr;
  assign out_addr     = wr_idx;
  assign out_data     = wr ? wb_data : '0;
  assign busy         = (state_reg != ST_IDLE);
  assign done         = (state_reg == ST_DONE);

endmodule

// File: tb/tb_pe_feeder.sv
// Testbench for pe_feeder: directed jobs from the block's test list followed by random jobs.
// A reference model expands each job into the expected read/ctl/write/done streams; a
// monitor pops and compares them whenever the DUT presents the corresponding output.
module tb_pe_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  in_chunks = '0;
  logic [7:0]  out_num = '0;
  logic        pe_vld_o = 1'b0;
  logic [31:0] pe_result = '0;

  logic        neuron_rd_en;
  logic [7:0]  neuron_addr;
  logic        weight_rd_en;
  logic [15:0] weight_addr;
  logic        pe_vld;
  logic [1:0]  pe_ctl;
  logic        out_wr_en;
  logic [7:0]  out_addr;
  logic [31:0] out_data;
  logic        busy;
  logic        done;

  pe_feeder #(.CNT_W(8), .OUT_W(8), .WADDR_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_chunks    (in_chunks),
    .out_num      (out_num),
    .neuron_rd_en (neuron_rd_en),
    .neuron_addr  (neuron_addr),
    .weight_rd_en (weight_rd_en),
    .weight_addr  (weight_addr),
    .pe_vld       (pe_vld),
    .pe_ctl       (pe_ctl),
    .pe_vld_o     (pe_vld_o),
    .pe_result    (pe_result),
    .out_wr_en    (out_wr_en),
    .out_addr     (out_addr),
    .out_data     (out_data),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int na;
    int wa;
    bit first_of_job;
    bit last_chunk;
  } rd_t;

  rd_t exp_rd[$];
  int  exp_ctl[$];
  int  exp_wa[$];
  int  exp_done[$];      // 1 = normal job (latency checked), 0 = empty job
  int  last_iss_cyc[$];
  int  last_wr_cyc = 0;
  bit  prev_rd = 0;
  bit  pe_pend = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_data(input logic [31:0] r);
`ifdef PE_FEEDER_RELU_EN
    return r[31] ? 32'h0 : r;
`else
    return r;
`endif
  endfunction

  function automatic logic [31:0] pick_result();
    case ($urandom_range(0, 3))
      0:       return 32'hFFFF_FFF0;
      1:       return 32'h0000_0010;
      default: return $urandom;
    endcase
  endfunction

  // PE model: a result appears in the cycle after the last-chunk vld is seen.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      pe_vld_o  = pe_pend;
      pe_result = pick_result();
      @(negedge clk);
      pe_pend = pe_vld && pe_ctl[1];
    end
  end

  // Monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (neuron_rd_en || weight_rd_en) begin
        if (exp_rd.size() == 0) begin
          chk("unexpected_read", neuron_rd_en | weight_rd_en, 0);
        end else begin
          rd_t e;
          e = exp_rd.pop_front();
          chk("rd_en_pair", {neuron_rd_en, weight_rd_en}, 2'b11);
          chk("neuron_addr", neuron_addr, e.na);
          chk("weight_addr", weight_addr, e.wa);
          if (!e.first_of_job) chk("rd_back_to_back", prev_rd, 1);
          if (e.last_chunk) last_iss_cyc.push_back(cyc);
          $display("[TB] rd   cyc=%0d neuron=%0d weight=%0d", cyc, neuron_addr, weight_addr);
        end
      end
      prev_rd = neuron_rd_en || weight_rd_en;

      if (pe_vld) begin
        if (exp_ctl.size() == 0) chk("unexpected_pe_vld", pe_vld, 0);
        else chk("pe_ctl", pe_ctl, exp_ctl.pop_front());
      end else begin
        chk("pe_ctl_without_vld", pe_ctl, 0);
      end

      if (out_wr_en) begin
        if (exp_wa.size() == 0) begin
          chk("unexpected_write", out_wr_en, 0);
        end else begin
          chk("out_addr", out_addr, exp_wa.pop_front());
          chk("out_data", out_data, model_data(pe_result));
          if (last_iss_cyc.size() == 0) chk("write_without_issue", out_wr_en, 0);
          else chk("write_latency", cyc, last_iss_cyc.pop_front() + 2);
          $display("[TB] wr   cyc=%0d addr=%0d data=%08h pe_result=%08h", cyc, out_addr, out_data, pe_result);
        end
        last_wr_cyc = cyc;
      end

      if (done) begin
        if (exp_done.size() == 0) begin
          chk("unexpected_done", done, 0);
        end else begin
          int k;
          k = exp_done.pop_front();
          if (k == 1) chk("done_latency", cyc, last_wr_cyc + 1);
          $display("[TB] done cyc=%0d", cyc);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_neuron_rd_en"}, neuron_rd_en, 0);
    chk({tag, "_weight_rd_en"}, weight_rd_en, 0);
    chk({tag, "_neuron_addr"}, neuron_addr, 0);
    chk({tag, "_weight_addr"}, weight_addr, 0);
    chk({tag, "_pe_vld"}, pe_vld, 0);
    chk({tag, "_pe_ctl"}, pe_ctl, 0);
    chk({tag, "_out_wr_en"}, out_wr_en, 0);
    chk({tag, "_out_addr"}, out_addr, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic clear_expect();
    exp_rd.delete();
    exp_ctl.delete();
    exp_wa.delete();
    exp_done.delete();
    last_iss_cyc.delete();
    prev_rd = 0;
  endtask

  // Runs one job; rep re-pulses start mid-job, abort_at>=0 resets the DUT at that cycle.
  task automatic run_job(input int ic, input int on, input bit rep, input int abort_at);
    int  nb;
    bit  got;
    int  exp_busy;
    rd_t e;
    if (ic != 0 && on != 0) begin
      for (int o = 0; o < on; o++) begin
        for (int i = 0; i < ic; i++) begin
          e.na = i;
          e.wa = o * ic + i;
          e.first_of_job = (o == 0) && (i == 0);
          e.last_chunk = (i == ic - 1);
          exp_rd.push_back(e);
          exp_ctl.push_back(((i == ic - 1) ? 2 : 0) + ((i == 0) ? 1 : 0));
        end
        exp_wa.push_back(o);
      end
      exp_done.push_back(1);
      exp_busy = ic * on + 3;
    end else begin
      exp_done.push_back(0);
      exp_busy = 1;
    end
    $display("[TB] job  in_chunks=%0d out_num=%0d repulse=%0d abort_at=%0d", ic, on, rep, abort_at);

    @(posedge clk);
    #1;
    in_chunks = 8'(ic);
    out_num   = 8'(on);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    in_chunks = 8'($urandom_range(1, 7));
    out_num   = 8'($urandom_range(1, 7));

    nb  = 0;
    got = 0;
    for (int n = 0; n < ic * on + 20; n++) begin
      @(negedge clk);
      if (n == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        clear_expect();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_busy_idle", busy, 0);
        return;
      end
      if (busy) nb++;
      if (done) begin
        got = 1;
        break;
      end
      start = rep && (n == 1);
    end
    start = 1'b0;
    chk("done_seen", got, 1);
    chk("busy_cycles", nb, exp_busy);
    @(negedge clk);
    chk("done_single_pulse", done, 0);
    chk("rd_queue_drained", exp_rd.size(), 0);
    chk("ctl_queue_drained", exp_ctl.size(), 0);
    chk("wr_queue_drained", exp_wa.size(), 0);
    chk("done_queue_drained", exp_done.size(), 0);
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2 check_all_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_job(2, 3, 0, -1);
    run_job(1, 2, 0, -1);
    run_job(0, 5, 0, -1);
    run_job(3, 0, 0, -1);
    run_job(3, 2, 1, -1);
    run_job(3, 3, 0, 4);
    run_job(2, 2, 0, -1);
    for (int j = 0; j < 24; j++) begin
      run_job($urandom_range(0, 5), $urandom_range(0, 5), 1'($urandom_range(0, 1)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
